// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between the icache (port 0,
// read fills only) and the dcache (port 1, fills and flushes).
//
// Arbitration is round-robin per transaction. A granted transaction of len words
// is split into memory bursts of mem_burstlen words. The address steps forward
// by one burst after each burst and wraps modulo 2^32.
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   c0_addr/c0_rdreq/c0_len               port0 read request (level, held until done)
//   c0_rddata/c0_datavalid/c0_done        port0 read data strobe, completion pulse
//   c1_addr/c1_rdreq/c1_wrreq/c1_len      port1 request (rdreq wins over wrreq)
//   c1_wrdata/c1_wrnext                   port1 write word / word-consumed strobe
//   c1_rddata/c1_datavalid/c1_done        port1 read data strobe, completion pulse
//   mem_addr/mem_rdreq/mem_wrreq          burst start address and request pulses
//   mem_burstlen                          words per burst (0 behaves as 1)
//   mem_wrdata/mem_rddata/mem_datavalid   memory data beat interface
//   owner                                 current / last granted port
module mem_arbiter #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      c0_addr,
  input  logic             c0_rdreq,
  input  logic [LEN_W-1:0] c0_len,
  output logic [31:0]      c0_rddata,
  output logic             c0_datavalid,
  output logic             c0_done,
  input  logic [31:0]      c1_addr,
  input  logic             c1_rdreq,
  input  logic             c1_wrreq,
  input  logic [LEN_W-1:0] c1_len,
  input  logic [31:0]      c1_wrdata,
  output logic             c1_wrnext,
  output logic [31:0]      c1_rddata,
  output logic             c1_datavalid,
  output logic             c1_done,
  output logic [31:0]      mem_addr,
  output logic             mem_rdreq,
  output logic             mem_wrreq,
  input  logic [LEN_W-1:0] mem_burstlen,
  output logic [31:0]      mem_wrdata,
  input  logic [31:0]      mem_rddata,
  input  logic             mem_datavalid,
  output logic             owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q, total_q, bcnt_q, blen_q;
  logic             dir_q;          // 1 = write (port 1 flush)
  logic             owner_q, last_owner_q;
  logic             mem_rdreq_q, mem_wrreq_q;
  logic [31:0]      c0_rddata_q, c1_rddata_q;
  logic             c0_datavalid_q, c1_datavalid_q, c0_done_q, c1_done_q;

  logic             pend0, pend1, grant1;
  logic [LEN_W-1:0] total_d, bcnt_d, len_d;

  assign pend0   = c0_rdreq;
  assign pend1   = c1_rdreq | c1_wrreq;
  // On a tie the port that did not win last time gets the grant.
  assign grant1  = pend1 & (~pend0 | ~last_owner_q);
  assign len_d   = grant1 ? c1_len : c0_len;
  assign total_d = total_q + 1'b1;
  assign bcnt_d  = bcnt_q + 1'b1;

  // Write data is passed straight through; the word is consumed on the same
  // cycle the memory accepts it.
  assign mem_wrdata = c1_wrdata;
  assign c1_wrnext  = (state_q == S_XFER) & dir_q & mem_datavalid;

  assign mem_addr     = addr_q;
  assign mem_rdreq    = mem_rdreq_q;
  assign mem_wrreq    = mem_wrreq_q;
  assign owner        = owner_q;
  assign c0_rddata    = c0_rddata_q;
  assign c1_rddata    = c1_rddata_q;
  assign c0_datavalid = c0_datavalid_q;
  assign c1_datavalid = c1_datavalid_q;
  assign c0_done      = c0_done_q;
  assign c1_done      = c1_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      total_q        <= '0;
      bcnt_q         <= '0;
      blen_q         <= '0;
      dir_q          <= 1'b0;
      owner_q        <= 1'b0;
      last_owner_q   <= 1'b1;
      mem_rdreq_q    <= 1'b0;
      mem_wrreq_q    <= 1'b0;
      c0_rddata_q    <= '0;
      c1_rddata_q    <= '0;
      c0_datavalid_q <= 1'b0;
      c1_datavalid_q <= 1'b0;
      c0_done_q      <= 1'b0;
      c1_done_q      <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      mem_rdreq_q    <= 1'b0;
      mem_wrreq_q    <= 1'b0;
      c0_datavalid_q <= 1'b0;
      c1_datavalid_q <= 1'b0;
      c0_done_q      <= 1'b0;
      c1_done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend0 | pend1) begin
            owner_q <= grant1;
            addr_q  <= (grant1 ? c1_addr : c0_addr) & ~32'h3;
            len_q   <= len_d;
            dir_q   <= grant1 & ~c1_rdreq;
            total_q <= '0;
            bcnt_q  <= '0;
            if (len_d == '0) begin
              // Empty transaction completes without touching memory.
              state_q   <= S_DONE;
              c0_done_q <= ~grant1;
              c1_done_q <= grant1;
            end else begin
              state_q     <= S_ISSUE;
              mem_rdreq_q <= ~(grant1 & ~c1_rdreq);
              mem_wrreq_q <= grant1 & ~c1_rdreq;
            end
          end
        end
        S_ISSUE: begin
          blen_q  <= (mem_burstlen == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : mem_burstlen;
          state_q <= S_XFER;
        end
        S_XFER: begin
          if (mem_datavalid) begin
            total_q <= total_d;
            if (!dir_q) begin
              if (owner_q) begin
                c1_rddata_q    <= mem_rddata;
                c1_datavalid_q <= 1'b1;
              end else begin
                c0_rddata_q    <= mem_rddata;
                c0_datavalid_q <= 1'b1;
              end
            end
            if (total_d == len_q) begin
              state_q   <= S_DONE;
              c0_done_q <= ~owner_q;
              c1_done_q <= owner_q;
            end else if (bcnt_d == blen_q) begin
              // Next burst starts right after the one just completed.
              addr_q      <= addr_q + {{(30-LEN_W){1'b0}}, blen_q, 2'b00};
              bcnt_q      <= '0;
              state_q     <= S_ISSUE;
              mem_rdreq_q <= ~dir_q;
              mem_wrreq_q <= dir_q;
            end else begin
              bcnt_q <= bcnt_d;
            end
          end
        end
        S_DONE: begin
          last_owner_q <= owner_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
